// File: rtl/base_ram_ctrl_pkg.sv
// Shared definitions for the base-RAM controller: SRAM strobe levels,
// base-RAM window bounds and a helper for sizing the wait counter.
package base_ram_ctrl_pkg;

  // SRAM control strobes are active-low.
  localparam logic RAM_ENABLE  = 1'b0;
  localparam logic RAM_DISABLE = 1'b1;

  // Base-RAM window, shared with the MEM-stage address decode.
  localparam logic [31:0] BASE_RAM_LO = 32'h8000_0000;
  localparam logic [31:0] BASE_RAM_HI = 32'h803F_FFFF;

  // Width of a counter able to hold wait_cycles; never narrower than 1 bit.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

  // True when a byte address falls inside the base-RAM window.
  function automatic logic in_base_ram(input logic [31:0] addr);
    return (addr >= BASE_RAM_LO) && (addr <= BASE_RAM_HI);
  endfunction

endpackage

// File: rtl/base_ram_ctrl_if.sv
// MEM-stage request bus into the base-RAM controller.
// The MEM stage is the master; the controller is the slave.
interface base_ram_ctrl_if;
  logic        req;    // held until ack
  logic        we;     // 1 = store, 0 = load
  logic [31:0] addr;   // byte address
  logic [31:0] wdata;  // store data
  logic [3:0]  be_n;   // byte enables, active-low
  logic [31:0] rdata;  // load data, valid while ack is high
  logic        ack;    // high in the final cycle of an access

  modport master (output req, we, addr, wdata, be_n, input rdata, ack);
  modport slave  (input req, we, addr, wdata, be_n, output rdata, ack);
endinterface

// File: rtl/base_ram_ctrl_sram_wait_cnt.sv
// Loadable down-counter with a terminal-count flag, used to time SRAM
// strobes. Loading WAIT_CYCLES gives WAIT_CYCLES+1 cycles until tc.
module sram_wait_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;

  // Load takes priority; otherwise count down and stick at zero.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = load_val;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tc = (cnt_reg == '0);

endmodule

// File: rtl/base_ram_ctrl.sv
// Base-RAM port controller: turns PC-stage fetches and MEM-stage
// loads/stores into timed SRAM cycles, data accesses taking priority
// at access boundaries.
module base_ram_ctrl
  import base_ram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  // PC stage / IF-ID
  input  logic [31:0]          if_pc_i,
  input  logic                 if_ce_n_i,
  output logic [31:0]          inst_o,
  output logic [31:0]          inst_pc_o,
  output logic                 inst_valid_o,
  output logic                 if_stallreq_o,
  // MEM stage
  base_ram_ctrl_if.slave       mem,
  // SRAM pins
  output logic [19:0]          ram_addr_o,
  output logic [3:0]           ram_be_n_o,
  output logic                 ram_ce_n_o,
  output logic                 ram_oe_n_o,
  output logic                 ram_we_n_o,
  output logic [31:0]          ram_wdata_o,
  output logic                 ram_data_oe_o,
  input  logic [31:0]          ram_rdata_i
);

  localparam int              CNT_W    = cnt_width(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DREAD,
    ST_WSETUP,
    ST_WPULSE,
    ST_WHOLD
  } state_t;

  state_t state_reg, state_next;

  logic        cnt_load;
  logic        cnt_tc;
  logic        capture;
  logic [31:0] inst_reg;
  logic [31:0] inst_pc_reg;
  logic        inst_valid_reg;

  // Wait counter is reloaded on every state entry (including a
  // back-to-back fetch re-entering FETCH).
  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (CNT_LOAD),
    .tc       (cnt_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a running fetch finishes before a data request is taken.
  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    capture    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_load = 1'b1;
        if (mem.req) begin
          state_next = mem.we ? ST_WSETUP : ST_DREAD;
        end else if (!if_ce_n_i) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (if_ce_n_i) begin
          // Fetch withdrawn: abandon it without a valid pulse.
          state_next = ST_IDLE;
          cnt_load   = 1'b1;
        end else if (cnt_tc) begin
          capture  = 1'b1;
          cnt_load = 1'b1;
          if (mem.req) begin
            state_next = mem.we ? ST_WSETUP : ST_DREAD;
          end else begin
            state_next = ST_FETCH;
          end
        end
      end
      ST_DREAD: begin
        if (cnt_tc) begin
          state_next = ST_IDLE;
          cnt_load   = 1'b1;
        end
      end
      ST_WSETUP: begin
        state_next = ST_WPULSE;
        cnt_load   = 1'b1;
      end
      ST_WPULSE: begin
        if (cnt_tc) begin
          state_next = ST_WHOLD;
          cnt_load   = 1'b1;
        end
      end
      ST_WHOLD: begin
        state_next = ST_IDLE;
        cnt_load   = 1'b1;
      end
      default: begin
        state_next = ST_IDLE;
        cnt_load   = 1'b1;
      end
    endcase
  end

  // SRAM strobes and data-bus drive enable, decoded from the state alone.
  always_comb begin
    ram_ce_n_o    = RAM_DISABLE;
    ram_oe_n_o    = RAM_DISABLE;
    ram_we_n_o    = RAM_DISABLE;
    ram_data_oe_o = 1'b0;
    ram_be_n_o    = 4'b0000;
    case (state_reg)
      ST_FETCH, ST_DREAD: begin
        ram_ce_n_o = RAM_ENABLE;
        ram_oe_n_o = RAM_ENABLE;
      end
      ST_WSETUP, ST_WHOLD: begin
        ram_ce_n_o    = RAM_ENABLE;
        ram_data_oe_o = 1'b1;
        ram_be_n_o    = mem.be_n;
      end
      ST_WPULSE: begin
        ram_ce_n_o    = RAM_ENABLE;
        ram_we_n_o    = RAM_ENABLE;
        ram_data_oe_o = 1'b1;
        ram_be_n_o    = mem.be_n;
      end
      default: begin
      end
    endcase
  end

  // Instruction capture register; valid pulses for one cycle per capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_reg       <= '0;
      inst_pc_reg    <= '0;
      inst_valid_reg <= 1'b0;
    end else begin
      inst_valid_reg <= capture;
      if (capture) begin
        inst_reg    <= ram_rdata_i;
        inst_pc_reg <= if_pc_i;
      end
    end
  end

  assign inst_o       = inst_reg;
  assign inst_pc_o    = inst_pc_reg;
  assign inst_valid_o = inst_valid_reg;

  // Stall drops only on the capture edge so the PC advances exactly then.
  assign if_stallreq_o = ~if_ce_n_i & ~((state_reg == ST_FETCH) & cnt_tc);

  assign ram_addr_o  = (state_reg == ST_FETCH) ? if_pc_i[21:2] : mem.addr[21:2];
  assign ram_wdata_o = mem.wdata;

  assign mem.rdata = ram_rdata_i;
  assign mem.ack   = ((state_reg == ST_DREAD) & cnt_tc) | (state_reg == ST_WHOLD);

  // Address bits outside the SRAM word range are intentionally ignored.
  logic unused_bits;
  assign unused_bits = &{1'b0, if_pc_i[31:22], if_pc_i[1:0],
                         mem.addr[31:22], mem.addr[1:0]};

endmodule

// File: tb/tb_base_ram_ctrl.sv
// Directed bench for base_ram_ctrl: one instance with WAIT_CYCLES=1 on a
// small byte-enabled SRAM model, one with WAIT_CYCLES=0 on an
// address-pattern SRAM for the throughput check.
module tb_base_ram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %08h want %08h", tag, got, exp);
    end else begin
      $display("ok   %s: %08h", tag, got);
    end
  endtask

  // ---------------- WAIT_CYCLES = 1 instance ----------------
  logic        rst;
  logic [31:0] if_pc;
  logic        if_ce_n;
  logic [31:0] inst, inst_pc;
  logic        inst_valid, stall;
  logic [19:0] ram_addr;
  logic [3:0]  ram_be_n;
  logic        ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe;
  logic [31:0] ram_wdata, ram_rdata;
  logic [31:0] ram [0:255];

  base_ram_ctrl_if mem_bus ();

  base_ram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk           (clk),
    .rst           (rst),
    .if_pc_i       (if_pc),
    .if_ce_n_i     (if_ce_n),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .inst_valid_o  (inst_valid),
    .if_stallreq_o (stall),
    .mem           (mem_bus.slave),
    .ram_addr_o    (ram_addr),
    .ram_be_n_o    (ram_be_n),
    .ram_ce_n_o    (ram_ce_n),
    .ram_oe_n_o    (ram_oe_n),
    .ram_we_n_o    (ram_we_n),
    .ram_wdata_o   (ram_wdata),
    .ram_data_oe_o (ram_data_oe),
    .ram_rdata_i   (ram_rdata)
  );

  // PC stage: advance only while fetching and not stalled.
  always @(posedge clk) begin
    if (rst) if_pc <= 32'h8000_0000;
    else if (!if_ce_n && !stall) if_pc <= if_pc + 32'd4;
  end

  // SRAM model: preloaded during reset, byte writes while we_n is low.
  always @(posedge clk) begin
    if (rst) begin
      ram[8'h00] <= 32'h3C01_1234;
      ram[8'h01] <= 32'h2421_0001;
      ram[8'h02] <= 32'h8C22_0000;
      ram[8'h40] <= 32'h1111_2222;
      ram[8'h41] <= 32'h3333_4444;
      ram[8'h50] <= 32'hCAFE_F00D;
    end else if (!ram_ce_n && !ram_we_n) begin
      for (int b = 0; b < 4; b++)
        if (!ram_be_n[b]) ram[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end
  assign ram_rdata = ram[ram_addr[7:0]];

  // ---------------- WAIT_CYCLES = 0 instance ----------------
  logic        w0_rst;
  logic [31:0] w0_pc;
  logic        w0_ce_n;
  logic [31:0] w0_inst, w0_inst_pc;
  logic        w0_valid, w0_stall;
  logic [19:0] w0_ram_addr;
  logic [3:0]  w0_ram_be_n;
  logic        w0_ram_ce_n, w0_ram_oe_n, w0_ram_we_n, w0_ram_data_oe;
  logic [31:0] w0_ram_wdata, w0_ram_rdata;

  base_ram_ctrl_if w0_bus ();

  base_ram_ctrl #(.WAIT_CYCLES(0)) dut0 (
    .clk           (clk),
    .rst           (w0_rst),
    .if_pc_i       (w0_pc),
    .if_ce_n_i     (w0_ce_n),
    .inst_o        (w0_inst),
    .inst_pc_o     (w0_inst_pc),
    .inst_valid_o  (w0_valid),
    .if_stallreq_o (w0_stall),
    .mem           (w0_bus.slave),
    .ram_addr_o    (w0_ram_addr),
    .ram_be_n_o    (w0_ram_be_n),
    .ram_ce_n_o    (w0_ram_ce_n),
    .ram_oe_n_o    (w0_ram_oe_n),
    .ram_we_n_o    (w0_ram_we_n),
    .ram_wdata_o   (w0_ram_wdata),
    .ram_data_oe_o (w0_ram_data_oe),
    .ram_rdata_i   (w0_ram_rdata)
  );

  always @(posedge clk) begin
    if (w0_rst) w0_pc <= 32'h8000_1000;
    else if (!w0_ce_n && !w0_stall) w0_pc <= w0_pc + 32'd4;
  end
  assign w0_ram_rdata = {12'hABC, w0_ram_addr};

  // {ce_n, oe_n, we_n, data_oe}
  function automatic logic [31:0] strb();
    return {28'd0, ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe};
  endfunction

  localparam logic [31:0] S_IDLE = 32'hE;  // 1110
  localparam logic [31:0] S_RD   = 32'h2;  // 0010
  localparam logic [31:0] S_WSH  = 32'h7;  // 0111 setup/hold
  localparam logic [31:0] S_WP   = 32'h5;  // 0101 pulse

  initial begin
    logic [31:0] epc;
    rst = 1'b1; if_ce_n = 1'b1;
    mem_bus.req = 1'b0; mem_bus.we = 1'b0; mem_bus.addr = '0;
    mem_bus.wdata = '0; mem_bus.be_n = 4'hF;
    w0_rst = 1'b1; w0_ce_n = 1'b1;
    w0_bus.req = 1'b0; w0_bus.we = 1'b0; w0_bus.addr = '0;
    w0_bus.wdata = '0; w0_bus.be_n = 4'hF;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    check("rst_valid", {31'd0, inst_valid}, 32'h0);
    check("rst_strb", strb(), S_IDLE);
    check("rst0_strb", {28'd0, w0_ram_ce_n, w0_ram_oe_n, w0_ram_we_n, w0_ram_data_oe}, S_IDLE);

    // Fetch from 0x80000000, then back-to-back fetch of 0x80000004
    rst = 1'b0; if_ce_n = 1'b0;
    @(negedge clk);
    check("f1_strb", strb(), S_RD);
    check("f1_addr", {12'd0, ram_addr}, 32'h0);
    check("f1_stall", {31'd0, stall}, 32'h1);
    @(negedge clk);
    check("f1_last_stall", {31'd0, stall}, 32'h0);
    check("f1_last_valid", {31'd0, inst_valid}, 32'h0);
    @(negedge clk);
    check("f1_valid", {31'd0, inst_valid}, 32'h1);
    check("f1_inst", inst, 32'h3C01_1234);
    check("f1_pc", inst_pc, 32'h8000_0000);
    check("f2_strb", strb(), S_RD);
    check("f2_addr", {12'd0, ram_addr}, 32'h1);
    @(negedge clk);
    check("f2_mid_valid", {31'd0, inst_valid}, 32'h0);
    @(negedge clk);
    check("f2_valid", {31'd0, inst_valid}, 32'h1);
    check("f2_inst", inst, 32'h2421_0001);
    check("f2_pc", inst_pc, 32'h8000_0004);
    if_ce_n = 1'b1;
    @(negedge clk);
    check("abort_strb", strb(), S_IDLE);
    check("abort_valid", {31'd0, inst_valid}, 32'h0);

    // Load and fetch requested together: load first
    if_ce_n = 1'b0; mem_bus.req = 1'b1; mem_bus.we = 1'b0; mem_bus.addr = 32'h8000_0100;
    @(negedge clk);
    check("ld_addr", {12'd0, ram_addr}, 32'h40);
    check("ld_strb", strb(), S_RD);
    check("ld_ack0", {31'd0, mem_bus.ack}, 32'h0);
    check("ld_stall0", {31'd0, stall}, 32'h1);
    @(negedge clk);
    check("ld_ack1", {31'd0, mem_bus.ack}, 32'h1);
    check("ld_rdata", mem_bus.rdata, 32'h1111_2222);
    check("ld_stall1", {31'd0, stall}, 32'h1);
    mem_bus.req = 1'b0;
    @(negedge clk);
    check("ld_idle_strb", strb(), S_IDLE);
    check("ld_idle_ack", {31'd0, mem_bus.ack}, 32'h0);
    @(negedge clk);
    check("f3_strb", strb(), S_RD);
    check("f3_addr", {12'd0, ram_addr}, 32'h2);

    // Load raised in the first cycle of a fetch
    mem_bus.req = 1'b1; mem_bus.we = 1'b0; mem_bus.addr = 32'h8000_0104;
    @(negedge clk);
    check("f3_last_addr", {12'd0, ram_addr}, 32'h2);
    check("f3_last_stall", {31'd0, stall}, 32'h0);
    check("f3_last_ack", {31'd0, mem_bus.ack}, 32'h0);
    @(negedge clk);
    check("f3_valid", {31'd0, inst_valid}, 32'h1);
    check("f3_inst", inst, 32'h8C22_0000);
    check("f3_pc", inst_pc, 32'h8000_0008);
    check("ld2_addr", {12'd0, ram_addr}, 32'h41);
    check("ld2_strb", strb(), S_RD);
    @(negedge clk);
    check("ld2_ack", {31'd0, mem_bus.ack}, 32'h1);
    check("ld2_rdata", mem_bus.rdata, 32'h3333_4444);
    mem_bus.req = 1'b0; if_ce_n = 1'b1;
    @(negedge clk);
    check("ld2_idle", strb(), S_IDLE);

    // Store 0xDEADBEEF, low half only
    mem_bus.req = 1'b1; mem_bus.we = 1'b1; mem_bus.addr = 32'h8000_0140;
    mem_bus.wdata = 32'hDEAD_BEEF; mem_bus.be_n = 4'b1100;
    @(negedge clk);
    check("st_setup_strb", strb(), S_WSH);
    check("st_be", {28'd0, ram_be_n}, 32'hC);
    check("st_addr", {12'd0, ram_addr}, 32'h50);
    check("st_wdata", ram_wdata, 32'hDEAD_BEEF);
    check("st_setup_ack", {31'd0, mem_bus.ack}, 32'h0);
    @(negedge clk);
    check("st_pulse1", strb(), S_WP);
    @(negedge clk);
    check("st_pulse2", strb(), S_WP);
    check("st_pulse_ack", {31'd0, mem_bus.ack}, 32'h0);
    @(negedge clk);
    check("st_hold_strb", strb(), S_WSH);
    check("st_hold_ack", {31'd0, mem_bus.ack}, 32'h1);
    mem_bus.req = 1'b0;
    @(negedge clk);
    check("st_idle_strb", strb(), S_IDLE);
    check("st_idle_ack", {31'd0, mem_bus.ack}, 32'h0);

    // Read back
    mem_bus.req = 1'b1; mem_bus.we = 1'b0; mem_bus.be_n = 4'hF;
    @(negedge clk);
    check("rb_be", {28'd0, ram_be_n}, 32'h0);
    @(negedge clk);
    check("rb_ack", {31'd0, mem_bus.ack}, 32'h1);
    check("rb_rdata", mem_bus.rdata, 32'hCAFE_BEEF);
    mem_bus.req = 1'b0;
    @(negedge clk);

    // Reset during the write pulse
    mem_bus.req = 1'b1; mem_bus.we = 1'b1; mem_bus.addr = 32'h8000_0180;
    mem_bus.wdata = 32'h1234_5678; mem_bus.be_n = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    check("rw_pulse", strb(), S_WP);
    rst = 1'b1;
    @(negedge clk);
    check("rw_strb", strb(), S_IDLE);
    check("rw_ack", {31'd0, mem_bus.ack}, 32'h0);
    check("rw_valid", {31'd0, inst_valid}, 32'h0);
    check("rw_inst", inst, 32'h0);
    mem_bus.req = 1'b0; mem_bus.be_n = 4'hF; rst = 1'b0;
    @(negedge clk);

    // WAIT_CYCLES=0: one instruction per cycle
    w0_rst = 1'b0; w0_ce_n = 1'b0;
    @(negedge clk);
    check("w0_first_valid", {31'd0, w0_valid}, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      epc = 32'h8000_1000 + 32'(4 * i);
      check($sformatf("w0_valid%0d", i), {31'd0, w0_valid}, 32'h1);
      check($sformatf("w0_pc%0d", i), w0_inst_pc, epc);
      check($sformatf("w0_inst%0d", i), w0_inst, {12'hABC, epc[21:2]});
    end
    w0_ce_n = 1'b1;
    @(negedge clk);
    check("w0_stop_valid", {31'd0, w0_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/base_ram_ctrl.md
# base_ram_ctrl

Base-RAM port controller sitting directly downstream of the PC stage. It turns the fetch address and active-low fetch enable into timed SRAM read cycles, and returns each instruction with its PC to the IF/ID register. It also arbitrates the same SRAM for MEM-stage loads and stores in the base-RAM window, raising an IF stall request while the port is busy.

## Interface
- WAIT_CYCLES, 1: extra cycles each SRAM read or write-enable pulse is held; an access strobe lasts WAIT_CYCLES+1 cycles (0 is legal).
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- if_pc_i  in  32  fetch address from the PC stage; stable while if_stallreq_o is high
- if_ce_n_i  in  1  fetch enable, active-low
- inst_o  out  32  last fetched instruction, registered
- inst_pc_o  out  32  address of inst_o, registered
- inst_valid_o  out  1  one-cycle pulse: inst_o/inst_pc_o are new
- if_stallreq_o  out  1  combinational stall request to the stall controller
- mem_req_i  in  1  MEM-stage base-RAM request; held until mem_ack_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data
- mem_be_n_i  in  4  byte enables, active-low
- mem_rdata_o  out  32  load data, valid while mem_ack_o is high
- mem_ack_o  out  1  combinational, high in the final cycle of a data access
- ram_addr_o  out  20  word address, bits [21:2] of the selected address
- ram_be_n_o  out  4  byte enables; 4'b0000 for reads
- ram_ce_n_o, ram_oe_n_o, ram_we_n_o  out  1 each  SRAM strobes, active-low
- ram_wdata_o  out  32  write data
- ram_data_oe_o  out  1  drive enable for the top-level tristate on the data bus
- ram_rdata_i  in  32  sampled data bus

## Operation
- States: IDLE, FETCH, DREAD, WSETUP, WPULSE, WHOLD. A wait counter `cnt` is cleared on every state entry.
- Strobes by state:
  - IDLE: all strobes high; ram_data_oe_o=0.
  - FETCH and DREAD: ce_n=0, oe_n=0, we_n=1.
  - WSETUP, WPULSE, WHOLD: ce_n=0, oe_n=1, ram_data_oe_o=1. we_n=0 only in WPULSE.
- ram_addr_o in FETCH is if_pc_i[21:2], taken combinationally; in the data states it is mem_addr_i[21:2].
- Leaving IDLE:
  - Priority: mem_req_i wins over a fetch. With mem_we_i=1 go to WSETUP, else DREAD.
  - Otherwise, if if_ce_n_i=0, go to FETCH.
- FETCH:
  - Lasts WAIT_CYCLES+1 cycles.
  - On the final cycle's edge: inst_o<=ram_rdata_i, inst_pc_o<=if_pc_i, inst_valid_o<=1.
  - Next state: DREAD/WSETUP if mem_req_i, else FETCH (back-to-back, cnt cleared) if if_ce_n_i=0, else IDLE.
  - An in-progress fetch is never aborted by mem_req_i.
  - if_ce_n_i going high mid-fetch: go to IDLE, no valid pulse.
- DREAD: lasts WAIT_CYCLES+1 cycles. mem_rdata_o=ram_rdata_i. mem_ack_o=1 in the final cycle, then go to IDLE.
- Write sequence: WSETUP is 1 cycle, WPULSE lasts WAIT_CYCLES+1 cycles, WHOLD is 1 cycle. mem_ack_o=1 in WHOLD, then go to IDLE.
- if_stallreq_o = ~if_ce_n_i & ~(state==FETCH & cnt==WAIT_CYCLES). It is therefore high during IDLE, data states and non-final fetch cycles, so the PC advances on exactly the edge where the instruction is captured.
- The block does not observe branches. The PC stage only changes the PC while unstalled, so the fetch address is always coherent.

## Timing
- Reset values: state IDLE, cnt 0, inst_o 0, inst_pc_o 0, inst_valid_o 0. Strobes de-asserted and ram_data_oe_o=0 from the cycle after the reset edge, mid-access included.
- Fetch latency: WAIT_CYCLES+1 cycles from FETCH entry to the capture edge. Sustained throughput is one instruction per WAIT_CYCLES+1 cycles.
- First fetch after reset release costs one extra IDLE cycle.
- Load: WAIT_CYCLES+1 cycles. Store: WAIT_CYCLES+3 cycles.
- The requester drops mem_req_i on the edge after mem_ack_o, and the block returns to IDLE on that same edge, so a held request is never serviced twice.
- inst_valid_o is high for exactly one cycle per captured instruction.

## Structure
- In defines.v: SRAM strobe levels (`RamEnable`/`RamDisable`) and the base-RAM window bounds, shared with the MEM-stage address decode.
- State encodings stay local to this block.
- One natural sub-module: sram_wait_cnt, a loadable down-counter with a terminal-count flag, reused by the ext-RAM controller.

## Test plan
- WAIT_CYCLES=1, rst released, if_ce_n_i=0, PC 0x80000000, RAM word 0 = 0x3C011234 -> ce_n/oe_n low for 2 cycles. inst_valid_o pulses with inst_o=0x3C011234 and inst_pc_o=0x80000000. PC then advances to 0x80000004 and the next FETCH follows back-to-back.
- mem_req_i and fetch asserted together in IDLE (load, addr 0x80000100) -> DREAD first with ram_addr_o=0x00040. mem_ack_o high in cycle 2, with if_stallreq_o high throughout. FETCH follows.
- mem_req_i raised in cycle 1 of a FETCH -> fetch completes with valid, then DREAD with no idle gap.
- Store 0xDEADBEEF, mem_be_n_i=4'b1100, WAIT_CYCLES=1 -> we_n low for exactly 2 cycles, bracketed by setup and hold cycles with ram_data_oe_o=1. mem_ack_o in WHOLD. A read-back returns 0x????BEEF with the upper bytes unchanged.
- rst asserted in WPULSE -> the next cycle has all strobes high, ram_data_oe_o=0, inst_valid_o=0, and no mem_ack_o.
- WAIT_CYCLES=0, 8 sequential fetches -> 8 inst_valid_o pulses in 8 consecutive cycles, with matching PCs.
